// File: rtl/event_qualifier.sv
// Event qualifier: synchronises an asynchronous event level, debounces it with
// a four-state qualification FSM, emits one count pulse per qualified rising
// event and keeps a saturating count of rejected (too short) transitions.
module event_qualifier #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       nReset,
    input  logic       event_in,
    input  logic       enable,
    input  logic       clr_glitch,
    output logic       cnt_up,
    output logic       stable_level,
    output logic [7:0] glitch_cnt
);

    localparam int unsigned CNT_W    = 8;
    localparam int unsigned GLITCH_W = 8;

    localparam logic [CNT_W-1:0]    DEB_MAX    = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]    DEB_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]    DEB_ZERO   = '0;
    localparam logic [GLITCH_W-1:0] GLITCH_SAT = '1;
    localparam logic [GLITCH_W-1:0] GLITCH_ONE = GLITCH_W'(1);

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_QUAL_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_QUAL_LOW  = 2'd3
    } state_t;

    // Synchroniser chain: bit 0 captures the raw input, the top bit is used.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced_c;

    state_t                 state_q,   state_d;
    logic [CNT_W-1:0]       deb_cnt_q, deb_cnt_d;
    logic [GLITCH_W-1:0]    glitch_q,  glitch_d;
    logic                   cnt_up_q,  cnt_up_d;
    logic                   stable_q,  stable_d;

    logic                   glitch_inc_c;
    logic                   rise_qual_c;

    assign synced_c = sync_q[SYNC_STAGES-1];

    // Synchroniser flop chain, no logic between stages.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], event_in};
        end
    end

    // State, debounce counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            state_q   <= ST_LOW;
            deb_cnt_q <= DEB_ZERO;
            glitch_q  <= '0;
            cnt_up_q  <= 1'b0;
            stable_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
            glitch_q  <= glitch_d;
            cnt_up_q  <= cnt_up_d;
            stable_q  <= stable_d;
        end
    end

    // Qualification FSM: next state, debounce count and rejection/rise strobes.
    always_comb begin
        state_d      = state_q;
        deb_cnt_d    = deb_cnt_q;
        glitch_inc_c = 1'b0;
        rise_qual_c  = 1'b0;

        case (state_q)
            ST_LOW: begin
                if (synced_c) begin
                    state_d   = ST_QUAL_HIGH;
                    deb_cnt_d = DEB_ONE;
                end else begin
                    deb_cnt_d = DEB_ZERO;
                end
            end

            ST_QUAL_HIGH: begin
                if (!synced_c) begin
                    state_d      = ST_LOW;
                    deb_cnt_d    = DEB_ZERO;
                    glitch_inc_c = 1'b1;
                end else if (deb_cnt_q == DEB_MAX) begin
                    state_d     = ST_HIGH;
                    deb_cnt_d   = DEB_ZERO;
                    rise_qual_c = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_ONE;
                end
            end

            ST_HIGH: begin
                if (!synced_c) begin
                    state_d   = ST_QUAL_LOW;
                    deb_cnt_d = DEB_ONE;
                end
            end

            ST_QUAL_LOW: begin
                if (synced_c) begin
                    state_d      = ST_HIGH;
                    deb_cnt_d    = DEB_ZERO;
                    glitch_inc_c = 1'b1;
                end else if (deb_cnt_q == DEB_MAX) begin
                    state_d   = ST_LOW;
                    deb_cnt_d = DEB_ZERO;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_ONE;
                end
            end

            default: begin
                state_d   = ST_LOW;
                deb_cnt_d = DEB_ZERO;
            end
        endcase
    end

    // Output next-values: pulse gated by enable, level follows the next state,
    // glitch counter saturates and a clear beats a same-cycle increment.
    always_comb begin
        cnt_up_d = rise_qual_c & enable;
        stable_d = (state_d == ST_HIGH) || (state_d == ST_QUAL_LOW);
        glitch_d = glitch_q;
        if (clr_glitch) begin
            glitch_d = '0;
        end else if (glitch_inc_c && (glitch_q != GLITCH_SAT)) begin
            glitch_d = glitch_q + GLITCH_ONE;
        end
    end

    assign cnt_up       = cnt_up_q;
    assign stable_level = stable_q;
    assign glitch_cnt   = glitch_q;

endmodule

// File: tb/tb_event_qualifier.sv
// Directed bench for event_qualifier with default parameters (2 sync stages,
// 8 debounce cycles). Inputs change 1 ns after a rising edge and outputs are
// sampled at the same point, so "tick i" observes the result of edge Ei.
module tb_event_qualifier;

    logic       clk = 1'b0;
    logic       nReset;
    logic       event_in;
    logic       enable;
    logic       clr_glitch;
    logic       cnt_up;
    logic       stable_level;
    logic [7:0] glitch_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    event_qualifier #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk          (clk),
        .nReset       (nReset),
        .event_in     (event_in),
        .enable       (enable),
        .clr_glitch   (clr_glitch),
        .cnt_up       (cnt_up),
        .stable_level (stable_level),
        .glitch_cnt   (glitch_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: a 5-cycle high excursion followed by a quiet low period.
    task automatic pulse_short();
        event_in = 1'b1;
        repeat (5) tick();
        event_in = 1'b0;
        repeat (5) tick();
    endtask

    task automatic test_reset();
        nReset     = 1'b0;
        event_in   = 1'b1;
        enable     = 1'b1;
        clr_glitch = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (cnt_up !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_cnt_up: got %b want 0", cnt_up);
        end
        n_cmp++;
        if (stable_level !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_stable: got %b want 0", stable_level);
        end
        n_cmp++;
        if (glitch_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_glitch: got %0d want 0", glitch_cnt);
        end
        event_in = 1'b0;
        nReset   = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_rise();
        int pulses;
        pulses   = 0;
        enable   = 1'b1;
        event_in = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (cnt_up === 1'b1) pulses++;
            n_cmp++;
            if (cnt_up !== (i == 10)) begin
                n_bad++;
                $display("FAIL rise_cnt_up at E%0d: got %b want %b", i, cnt_up, (i == 10));
            end
            n_cmp++;
            if (stable_level !== (i >= 10)) begin
                n_bad++;
                $display("FAIL rise_stable at E%0d: got %b want %b", i, stable_level, (i >= 10));
            end
        end
        n_cmp++;
        if (pulses != 1) begin
            n_bad++;
            $display("FAIL rise_pulse_count: got %0d want 1", pulses);
        end
        n_cmp++;
        if (glitch_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL rise_glitch: got %0d want 0", glitch_cnt);
        end
        // Falling qualification: level drops after E10, never a pulse.
        event_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if (cnt_up !== 1'b0) begin
                n_bad++;
                $display("FAIL fall_cnt_up at E%0d: got %b want 0", i, cnt_up);
            end
            n_cmp++;
            if (stable_level !== (i < 10)) begin
                n_bad++;
                $display("FAIL fall_stable at E%0d: got %b want %b", i, stable_level, (i < 10));
            end
        end
    endtask

    task automatic test_glitch_rise();
        int pulses;
        int highs;
        pulses   = 0;
        highs    = 0;
        event_in = 1'b1;
        repeat (5) begin
            tick();
            if (cnt_up === 1'b1) pulses++;
            if (stable_level === 1'b1) highs++;
        end
        event_in = 1'b0;
        repeat (10) begin
            tick();
            if (cnt_up === 1'b1) pulses++;
            if (stable_level === 1'b1) highs++;
        end
        n_cmp++;
        if (glitch_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL glitch_first: got %0d want 1", glitch_cnt);
        end
        n_cmp++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL glitch_no_pulse: got %0d pulses want 0", pulses);
        end
        n_cmp++;
        if (highs != 0) begin
            n_bad++;
            $display("FAIL glitch_stable: got %0d high cycles want 0", highs);
        end
        for (int r = 0; r < 299; r++) begin
            pulse_short();
            if (r == 252) begin
                n_cmp++;
                if (glitch_cnt !== 8'd254) begin
                    n_bad++;
                    $display("FAIL glitch_254: got %0d want 254", glitch_cnt);
                end
            end
        end
        n_cmp++;
        if (glitch_cnt !== 8'd255) begin
            n_bad++;
            $display("FAIL glitch_saturate: got %0d want 255", glitch_cnt);
        end
        clr_glitch = 1'b1;
        tick();
        clr_glitch = 1'b0;
        n_cmp++;
        if (glitch_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL glitch_clear: got %0d want 0", glitch_cnt);
        end
    endtask

    task automatic test_glitch_dip();
        event_in = 1'b1;
        repeat (15) tick();
        n_cmp++;
        if (stable_level !== 1'b1) begin
            n_bad++;
            $display("FAIL dip_setup_stable: got %b want 1", stable_level);
        end
        event_in = 1'b0;
        repeat (4) tick();
        event_in = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            n_cmp++;
            if (cnt_up !== 1'b0 || stable_level !== 1'b1) begin
                n_bad++;
                $display("FAIL dip_hold at %0d: cnt_up %b stable %b want 0/1", i, cnt_up, stable_level);
            end
        end
        n_cmp++;
        if (glitch_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL dip_glitch: got %0d want 1", glitch_cnt);
        end
        event_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if (cnt_up !== 1'b0) begin
                n_bad++;
                $display("FAIL dip_fall_cnt_up at E%0d: got %b want 0", i, cnt_up);
            end
        end
        n_cmp++;
        if (stable_level !== 1'b0) begin
            n_bad++;
            $display("FAIL dip_fall_stable: got %b want 0", stable_level);
        end
        n_cmp++;
        if (glitch_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL dip_fall_glitch: got %0d want 1", glitch_cnt);
        end
    endtask

    task automatic test_enable();
        int pulses;
        pulses   = 0;
        enable   = 1'b0;
        event_in = 1'b1;
        repeat (15) begin
            tick();
            if (cnt_up === 1'b1) pulses++;
        end
        enable = 1'b1;
        repeat (10) begin
            tick();
            if (cnt_up === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL enable_lost: got %0d pulses want 0", pulses);
        end
        n_cmp++;
        if (stable_level !== 1'b1) begin
            n_bad++;
            $display("FAIL enable_stable: got %b want 1", stable_level);
        end
        event_in = 1'b0;
        repeat (15) tick();
        event_in = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            n_cmp++;
            if (cnt_up !== (i == 10)) begin
                n_bad++;
                $display("FAIL enable_rise at E%0d: got %b want %b", i, cnt_up, (i == 10));
            end
        end
        event_in = 1'b0;
        repeat (15) tick();
    endtask

    task automatic test_reset_mid();
        event_in = 1'b1;
        repeat (6) tick();
        nReset = 1'b0;
        tick();
        n_cmp++;
        if (cnt_up !== 1'b0 || stable_level !== 1'b0 || glitch_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL midreset_state: cnt_up %b stable %b glitch %0d want 0/0/0",
                     cnt_up, stable_level, glitch_cnt);
        end
        nReset = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            n_cmp++;
            if (cnt_up !== (i == 10)) begin
                n_bad++;
                $display("FAIL midreset_rise at E%0d: got %b want %b", i, cnt_up, (i == 10));
            end
        end
        event_in = 1'b0;
        repeat (15) tick();
    endtask

    task automatic test_clr_race();
        repeat (7) pulse_short();
        n_cmp++;
        if (glitch_cnt !== 8'd7) begin
            n_bad++;
            $display("FAIL race_setup: got %0d want 7", glitch_cnt);
        end
        // High sampled at E0..E4, rejection happens on E7.
        event_in = 1'b1;
        repeat (5) tick();
        event_in = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (glitch_cnt !== 8'd7) begin
            n_bad++;
            $display("FAIL race_before: got %0d want 7", glitch_cnt);
        end
        clr_glitch = 1'b1;
        tick();
        clr_glitch = 1'b0;
        n_cmp++;
        if (glitch_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL race_clear: got %0d want 0", glitch_cnt);
        end
        repeat (5) tick();
        n_cmp++;
        if (glitch_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL race_after: got %0d want 0", glitch_cnt);
        end
        pulse_short();
        n_cmp++;
        if (glitch_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL race_resume: got %0d want 1", glitch_cnt);
        end
    endtask

    initial begin
        nReset     = 1'b0;
        event_in   = 1'b0;
        enable     = 1'b0;
        clr_glitch = 1'b0;
        test_reset();
        test_rise();
        test_glitch_rise();
        test_glitch_dip();
        test_enable();
        test_reset_mid();
        test_clr_race();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/event_qualifier.md
EVENT_QUALIFIER -- requirements
Module: event_qualifier

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchroniser flops on event_in (legal range 2..4).
REQ-002 Parameter DEBOUNCE_CYCLES, default 8, value D, qualification length in clocks (legal range 1..255).
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port nReset  input  1  reset, synchronous and active-low.
REQ-005 Port event_in  input  1  asynchronous raw event level from off-chip or another clock domain.
REQ-006 Port enable  input  1  when 1, qualified rising events produce count pulses.
REQ-007 Port clr_glitch  input  1  synchronous clear of glitch_cnt.
REQ-008 Port cnt_up  output  1  single-cycle count pulse, drives the 16-bit counter's cnt_up input.
REQ-009 Port stable_level  output  1  current debounced level of event_in.
REQ-010 Port glitch_cnt  output  8  saturating count of rejected transitions.

Function
REQ-011 Synchroniser SHALL be a SYNC_STAGES-deep flop chain: s[0] <= event_in, s[k] <= s[k-1]; synced = s[SYNC_STAGES-1]; no logic between stages.
REQ-012 FSM SHALL have exactly four states: LOW, QUAL_HIGH, HIGH, QUAL_LOW; 8-bit deb_cnt accompanies it.
REQ-013 LOW: synced=1 -> QUAL_HIGH, deb_cnt <= 1; else stay, deb_cnt <= 0.
REQ-014 QUAL_HIGH: synced=0 -> LOW, deb_cnt <= 0, glitch increment; synced=1 and deb_cnt==D -> HIGH, deb_cnt <= 0; synced=1 and deb_cnt<D -> deb_cnt+1.
REQ-015 HIGH: synced=0 -> QUAL_LOW, deb_cnt <= 1; else stay.
REQ-016 QUAL_LOW: synced=1 -> HIGH, deb_cnt <= 0, glitch increment; synced=0 and deb_cnt==D -> LOW, deb_cnt <= 0; synced=0 and deb_cnt<D -> deb_cnt+1.
REQ-017 cnt_up SHALL be registered, 1 for exactly the cycle after the edge on which QUAL_HIGH -> HIGH occurs, and only if enable=1 at that edge; 0 at all other times.
REQ-018 Latency: with event_in sampled 1 at edge E0 and held, cnt_up is high in the cycle after edge E0+SYNC_STAGES+D (defaults: after E10).
REQ-019 A high or low excursion of synced lasting D or fewer cycles SHALL be rejected; D+1 consecutive cycles SHALL qualify.
REQ-020 At most one cnt_up per qualified rising event; falling qualification produces no pulse.
REQ-021 stable_level SHALL be registered, 1 when state is HIGH or QUAL_LOW, else 0.
REQ-022 enable SHALL not affect FSM, synchroniser or glitch_cnt; an event qualified with enable=0 is lost, not deferred.
REQ-023 glitch_cnt SHALL increment by 1 per rejection, saturate at 255, and be cleared to 0 when clr_glitch=1; clr_glitch wins over a simultaneous increment.

Reset
REQ-024 On a rising edge with nReset=0: synchroniser flops, deb_cnt, glitch_cnt, cnt_up, stable_level all 0; state LOW.
REQ-025 Reset mid-qualification SHALL abandon it with no pulse; an event_in held high across release requalifies from the first edge with nReset=1 (E0) per REQ-018.
REQ-026 No output may change asynchronously with nReset.

Verification
REQ-027 Defaults, enable=1, event_in 0->1 held 30 cycles -> exactly one cnt_up pulse, in cycle after E10; stable_level 1 from same cycle; glitch_cnt 0.
REQ-028 Defaults, event_in high 5 cycles then low -> no cnt_up, stable_level stays 0, glitch_cnt=1; repeat 300 times -> glitch_cnt=255.
REQ-029 Defaults, stable high then 4-cycle low dip -> no cnt_up, stable_level stays 1, glitch_cnt +1; then 20-cycle low -> stable_level 0, no pulse.
REQ-030 enable=0 during qualified rise -> no cnt_up; enable raised while still HIGH -> still no cnt_up; next qualified rise with enable=1 -> one pulse.
REQ-031 nReset low at E6 of a qualifying rise, released with event_in high -> no pulse at old timing; one pulse in cycle after release-edge+10.
REQ-032 clr_glitch=1 on the same edge as a rejection with glitch_cnt=7 -> glitch_cnt=0.
